datamem_port_arbiter: RTL and testbench

//  Single-port scheduler in front of cpu_datamem. Shares the one memory port among three requesters:
//  - EX-stage writes
//  - CPU load/store
//  - accelerator 512-bit block transfers, issued as BURST_LEN 32-bit beats

---
 rtl/datamem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_datamem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_port_arbiter.sv
`timescale 1ns/1ps
// datamem_port_arbiter: shares one data-memory port among EX writes, CPU accesses and accel bursts (EX > CPU > ACCEL).
// Latency: winner's command on mem_* one cycle after grant; CPU read data 2 cycles after grant; accel beats stride DATA_W/8.
// Backpressure: EX never stalled; CPU waits for cpu_gnt; accel write beats wait for accel_beat_rdy. ARB_STARVE_GUARD_EN adds an accel starvation guard.
module datamem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int BURST_LEN    = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ex_wrt_en,
   input  logic [ADDR_W-1:0]             ex_addr,
   input  logic [DATA_W-1:0]             ex_wrt_data,
   input  logic                          cpu_req,
   input  logic                          cpu_wrt,
   input  logic [ADDR_W-1:0]             cpu_addr,
   input  logic [DATA_W-1:0]             cpu_wrt_data,
   output logic                          cpu_gnt,
   output logic                          cpu_rd_vld,
   output logic [DATA_W-1:0]             cpu_rd_data,
   input  logic                          accel_req,
   input  logic                          accel_wrt,
   input  logic [ADDR_W-1:0]             accel_base,
   input  logic [DATA_W-1:0]             accel_wrt_data,
   output logic                          accel_beat_rdy,
   output logic                          accel_busy,
   output logic                          accel_done,
   output logic [BURST_LEN*DATA_W-1:0]   accel_rd_data,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wrt_data,
   output logic                          mem_wrt_en,
   output logic                          mem_rd_en,
   input  logic [DATA_W-1:0]             mem_rd_data
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int STRIDE = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic [BEAT_W-1:0]   beat;
   logic [ADDR_W-1:0]   base;
   logic                acc_wrt;
   logic                beat_gnt;
   logic                force_beat;
   logic                last_beat;
   logic [ADDR_W-1:0]   beat_addr;
   logic                p1_cpu, p1_acc, p2_cpu, p2_acc;
   logic [BEAT_W-1:0]   p1_idx, p2_idx;
   logic [DATA_W-1:0]   cpu_rd_hold;

   // Address arithmetic is ADDR_W wide so bursts wrap around the top of memory.
   assign beat_addr = base + ADDR_W'(beat) * ADDR_W'(STRIDE);
   assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));

   // Fixed priority: EX always wins, CPU next unless the guard forces a beat, accel takes leftovers.
   assign cpu_gnt  = cpu_req && !ex_wrt_en && !force_beat;
   assign beat_gnt = (state == BURST) && !ex_wrt_en && (!cpu_req || force_beat);

`ifdef ARB_STARVE_GUARD_EN
   localparam int SC_W = $clog2(STARVE_LIMIT + 1);
   logic [SC_W-1:0] starve_cnt;

   assign force_beat = (state == BURST) && (starve_cnt >= SC_W'(STARVE_LIMIT));

   // Count CPU wins over a pending beat; any beat grant (natural or forced) resets the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_cnt <= '0;
      else if (beat_gnt)
         starve_cnt <= '0;
      else if ((state == BURST) && cpu_gnt)
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   // Guard disabled: the CPU always beats the accelerator.
   assign force_beat = (STARVE_LIMIT < 0);
`endif

   // Burst state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Burst next-state and accel handshake outputs.
   always_comb begin
      state_nxt      = state;
      accel_busy     = 1'b0;
      accel_done     = 1'b0;
      accel_beat_rdy = 1'b0;
      case (state)
         IDLE: begin
            if (accel_req)
               state_nxt = BURST;
         end
         BURST: begin
            accel_busy     = 1'b1;
            accel_beat_rdy = beat_gnt && acc_wrt;
            if (beat_gnt && last_beat)
               state_nxt = acc_wrt ? DONE : DRAIN;
         end
         DRAIN: begin
            accel_busy = 1'b1;
            // Last return is in stage 2 and lands in the block register this edge.
            if (!p1_acc)
               state_nxt = DONE;
         end
         DONE: begin
            accel_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the burst descriptor on accept and step the beat counter on each granted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base    <= '0;
         acc_wrt <= 1'b0;
         beat    <= '0;
      end else if ((state == IDLE) && accel_req) begin
         base    <= accel_base;
         acc_wrt <= accel_wrt;
         beat    <= '0;
      end else if (beat_gnt) begin
         beat    <= beat + 1'b1;
      end
   end

   // Register the winning command onto the memory port; idle cycles drop both strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr     <= '0;
         mem_wrt_data <= '0;
         mem_wrt_en   <= 1'b0;
         mem_rd_en    <= 1'b0;
      end else if (ex_wrt_en) begin
         mem_addr     <= ex_addr;
         mem_wrt_data <= ex_wrt_data;
         mem_wrt_en   <= 1'b1;
         mem_rd_en    <= 1'b0;
      end else if (cpu_gnt) begin
         mem_addr     <= cpu_addr;
         mem_wrt_data <= cpu_wrt_data;
         mem_wrt_en   <= cpu_wrt;
         mem_rd_en    <= !cpu_wrt;
      end else if (beat_gnt) begin
         mem_addr     <= beat_addr;
         mem_wrt_data <= accel_wrt_data;
         mem_wrt_en   <= acc_wrt;
         mem_rd_en    <= !acc_wrt;
      end else begin
         mem_wrt_en   <= 1'b0;
         mem_rd_en    <= 1'b0;
      end
   end

   // Two-stage read-return tags: stage 1 rides with mem_rd_en, stage 2 marks data on mem_rd_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_cpu        <= 1'b0;
         p1_acc        <= 1'b0;
         p1_idx        <= '0;
         p2_cpu        <= 1'b0;
         p2_acc        <= 1'b0;
         p2_idx        <= '0;
         cpu_rd_hold   <= '0;
         accel_rd_data <= '0;
      end else begin
         p1_cpu <= cpu_gnt && !cpu_wrt;
         p1_acc <= beat_gnt && !acc_wrt;
         p1_idx <= beat;
         p2_cpu <= p1_cpu;
         p2_acc <= p1_acc;
         p2_idx <= p1_idx;
         if (p2_cpu)
            cpu_rd_hold <= mem_rd_data;
         if (p2_acc)
            accel_rd_data[p2_idx*DATA_W +: DATA_W] <= mem_rd_data;
      end
   end

   // CPU read data passes straight through on the return cycle, then holds.
   assign cpu_rd_vld  = p2_cpu;
   assign cpu_rd_data = p2_cpu ? mem_rd_data : cpu_rd_hold;

endmodule

// File: tb/tb_datamem_port_arbiter.sv
`timescale 1ns/1ps
// tb_datamem_port_arbiter: randomized bench with a word-level memory reference for datamem_port_arbiter.
// Latency: checks CPU read at grant+2, write burst done at +17, read burst done at +19.
// Backpressure: CPU requests held until granted; accel write data offered every cycle.
module tb_datamem_port_arbiter;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ex_wrt_en, cpu_req, cpu_wrt, accel_req, accel_wrt;
   logic [15:0]   ex_addr, cpu_addr, accel_base;
   logic [31:0]   ex_wrt_data, cpu_wrt_data, accel_wrt_data;
   logic          cpu_gnt, cpu_rd_vld, accel_beat_rdy, accel_busy, accel_done;
   logic [31:0]   cpu_rd_data;
   logic [511:0]  accel_rd_data;
   logic [15:0]   mem_addr;
   logic [31:0]   mem_wrt_data;
   logic          mem_wrt_en, mem_rd_en;
   logic [31:0]   mem_rd_data;

   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   logic [31:0]   mseed;

   logic [31:0]   ref_mem [0:16383];
   logic [31:0]   mem [0:16383];
   bit            written [0:16383];

   datamem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .ex_wrt_en(ex_wrt_en), .ex_addr(ex_addr), .ex_wrt_data(ex_wrt_data),
      .cpu_req(cpu_req), .cpu_wrt(cpu_wrt), .cpu_addr(cpu_addr), .cpu_wrt_data(cpu_wrt_data),
      .cpu_gnt(cpu_gnt), .cpu_rd_vld(cpu_rd_vld), .cpu_rd_data(cpu_rd_data),
      .accel_req(accel_req), .accel_wrt(accel_wrt), .accel_base(accel_base),
      .accel_wrt_data(accel_wrt_data), .accel_beat_rdy(accel_beat_rdy),
      .accel_busy(accel_busy), .accel_done(accel_done), .accel_rd_data(accel_rd_data),
      .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data), .mem_wrt_en(mem_wrt_en),
      .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int idx);
      return (idx * 32'h9E3779B1) ^ mseed;
   endfunction

   function automatic logic [31:0] env_word(input int idx);
      return written[idx] ? mem[idx] : init_word(idx);
   endfunction

   // Synchronous single-port memory: read data valid the cycle after mem_rd_en.
   always @(posedge clk) begin
      if (mem_wrt_en) begin
         mem[mem_addr[15:2]]     <= mem_wrt_data;
         written[mem_addr[15:2]] <= 1'b1;
      end
      if (mem_rd_en)
         mem_rd_data <= env_word(int'(mem_addr[15:2]));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ex_wrt_en = 0; ex_addr = 0; ex_wrt_data = 0;
      cpu_req = 0; cpu_wrt = 0; cpu_addr = 0; cpu_wrt_data = 0;
      accel_req = 0; accel_wrt = 0; accel_base = 0; accel_wrt_data = 0;
   endtask

   task automatic test_reset();
      logic [598:0] outs;
      repeat (3) sample();
      outs = {cpu_gnt, cpu_rd_vld, cpu_rd_data, accel_beat_rdy, accel_busy, accel_done,
              accel_rd_data, mem_addr, mem_wrt_data, mem_wrt_en, mem_rd_en};
      n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", outs); end
      step(); rst_n = 1;
   endtask

   task automatic test_ex_priority();
      step();
      ex_wrt_en = 1; ex_addr = 16'h0010; ex_wrt_data = 32'hDEADBEEF;
      cpu_req = 1; cpu_wrt = 0; cpu_addr = 16'h0080;
      ref_mem[16'h0010 >> 2] = 32'hDEADBEEF;
      sample();
      n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL ex_blocks_cpu: got %b want 0", cpu_gnt); end
      step(); ex_wrt_en = 0;
      sample();
      n_cmp++; if ({mem_wrt_en, mem_rd_en, mem_addr, mem_wrt_data} !== {2'b10, 16'h0010, 32'hDEADBEEF}) begin
         n_err++; $display("FAIL ex_write_cmd: got %b%b %h %h want 10 0010 deadbeef", mem_wrt_en, mem_rd_en, mem_addr, mem_wrt_data);
      end
      n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL cpu_after_ex: got %b want 1", cpu_gnt); end
      step(); cpu_req = 0;
      sample();
      n_cmp++; if ({mem_rd_en, mem_addr} !== {1'b1, 16'h0080}) begin
         n_err++; $display("FAIL cpu_read_cmd: got %b %h want 1 0080", mem_rd_en, mem_addr);
      end
      step();
      sample();
      n_cmp++; if ({cpu_rd_vld, cpu_rd_data} !== {1'b1, ref_mem[16'h0080 >> 2]}) begin
         n_err++; $display("FAIL cpu_read_ret: got %b %h want 1 %h", cpu_rd_vld, cpu_rd_data, ref_mem[16'h0080 >> 2]);
      end
      n_cmp++; if (env_word(4) !== 32'hDEADBEEF) begin n_err++; $display("FAIL ex_mem_word: got %h want deadbeef", env_word(4)); end
   endtask

   task automatic test_read_burst(input logic [15:0] base);
      logic [15:0]  addr_q[$];
      int           cyc_q[$];
      int           t0, done_at;
      logic [15:0]  a;
      logic [511:0] exp_blk;
      step(); accel_req = 1; accel_wrt = 0; accel_base = base;
      sample(); t0 = cyc;
      n_cmp++; if (accel_busy !== 1'b0) begin n_err++; $display("FAIL rd_idle_busy: got %b want 0", accel_busy); end
      done_at = -1;
      for (int k = 1; k <= 30 && done_at < 0; k++) begin
         step(); accel_req = 0;
         sample();
         if (mem_rd_en) begin addr_q.push_back(mem_addr); cyc_q.push_back(cyc - t0); end
         if (accel_done) done_at = cyc - t0;
      end
      n_cmp++; if (done_at != 19) begin n_err++; $display("FAIL rd_done_time: got %0d want 19", done_at); end
      n_cmp++; if (addr_q.size() != 16) begin n_err++; $display("FAIL rd_beat_count: got %0d want 16", addr_q.size()); end
      for (int i = 0; i < addr_q.size() && i < 16; i++) begin
         a = base + 16'(4 * i);
         n_cmp++; if (addr_q[i] !== a || cyc_q[i] != 2 + i) begin
            n_err++; $display("FAIL rd_beat%0d: got @%h cyc %0d want @%h cyc %0d", i, addr_q[i], cyc_q[i], a, 2 + i);
         end
      end
      for (int i = 0; i < 16; i++) begin
         a = base + 16'(4 * i);
         exp_blk[32*i +: 32] = ref_mem[a[15:2]];
      end
      n_cmp++; if (accel_rd_data !== exp_blk) begin n_err++; $display("FAIL rd_block: got %h want %h", accel_rd_data, exp_blk); end
      n_cmp++; if (accel_busy !== 1'b0) begin n_err++; $display("FAIL rd_done_busy: got %b want 0", accel_busy); end
   endtask

   task automatic test_write_burst(input logic [15:0] base);
      logic [15:0] waddr_q[$];
      logic [31:0] wdat_q[$];
      logic [31:0] bdat_q[$];
      int          t0, done_at, bad;
      logic [15:0] a;
      step(); accel_req = 1; accel_wrt = 1; accel_base = base; accel_wrt_data = $urandom;
      sample(); t0 = cyc;
      n_cmp++; if (accel_beat_rdy !== 1'b0) begin n_err++; $display("FAIL wr_idle_rdy: got %b want 0", accel_beat_rdy); end
      done_at = -1;
      for (int k = 1; k <= 30 && done_at < 0; k++) begin
         step(); accel_req = 0; accel_wrt_data = $urandom;
         sample();
         if (mem_wrt_en) begin waddr_q.push_back(mem_addr); wdat_q.push_back(mem_wrt_data); end
         if (accel_beat_rdy) bdat_q.push_back(accel_wrt_data);
         if (accel_done) done_at = cyc - t0;
      end
      n_cmp++; if (done_at != 17) begin n_err++; $display("FAIL wr_done_time: got %0d want 17", done_at); end
      n_cmp++; if (bdat_q.size() != 16) begin n_err++; $display("FAIL wr_rdy_pulses: got %0d want 16", bdat_q.size()); end
      n_cmp++; if (waddr_q.size() != 16) begin n_err++; $display("FAIL wr_bus_count: got %0d want 16", waddr_q.size()); end
      for (int i = 0; i < 16 && i < waddr_q.size() && i < bdat_q.size(); i++) begin
         a = base + 16'(4 * i);
         n_cmp++; if (waddr_q[i] !== a || wdat_q[i] !== bdat_q[i]) begin
            n_err++; $display("FAIL wr_beat%0d: got @%h %h want @%h %h", i, waddr_q[i], wdat_q[i], a, bdat_q[i]);
         end
         ref_mem[a[15:2]] = bdat_q[i];
      end
      step();
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         a = base + 16'(4 * i);
         if (env_word(int'(a[15:2])) !== ref_mem[a[15:2]]) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wr_mem_image: got %0d bad words want 0", bad); end
   endtask

   task automatic test_cpu_read_ex();
      logic [31:0] d;
      step(); cpu_req = 1; cpu_wrt = 0; cpu_addr = 16'h0020;
      sample();
      n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL rx_gnt: got %b want 1", cpu_gnt); end
      step(); cpu_req = 0; d = $urandom;
      ex_wrt_en = 1; ex_addr = 16'h0040; ex_wrt_data = d;
      sample();
      n_cmp++; if ({cpu_rd_vld, mem_rd_en, mem_addr} !== {2'b01, 16'h0020}) begin
         n_err++; $display("FAIL rx_cmd: got vld %b rd %b @%h want 0 1 @0020", cpu_rd_vld, mem_rd_en, mem_addr);
      end
      step(); ex_wrt_en = 0;
      sample();
      n_cmp++; if ({cpu_rd_vld, cpu_rd_data} !== {1'b1, ref_mem[16'h0020 >> 2]}) begin
         n_err++; $display("FAIL rx_ret: got %b %h want 1 %h", cpu_rd_vld, cpu_rd_data, ref_mem[16'h0020 >> 2]);
      end
      n_cmp++; if ({mem_wrt_en, mem_addr, mem_wrt_data} !== {1'b1, 16'h0040, d}) begin
         n_err++; $display("FAIL rx_ex_cmd: got %b @%h %h want 1 @0040 %h", mem_wrt_en, mem_addr, mem_wrt_data, d);
      end
      ref_mem[16'h0040 >> 2] = d;
   endtask

   task automatic test_random_traffic();
      int          due_q[$];
      logic [31:0] dat_q[$];
      logic        exp_gnt, granted_last;
      granted_last = 0;
      for (int k = 0; k < 303; k++) begin
         step();
         if (granted_last) cpu_req = 0;
         ex_wrt_en = (k < 300) && ($urandom_range(3) == 0);
         ex_addr = 16'($urandom_range(63)) << 2; ex_wrt_data = $urandom;
         if (!cpu_req && k < 300 && $urandom_range(1) == 1) begin
            cpu_req = 1; cpu_wrt = 1'($urandom_range(1));
            cpu_addr = 16'($urandom_range(63)) << 2; cpu_wrt_data = $urandom;
         end
         sample();
         exp_gnt = cpu_req && !ex_wrt_en;
         n_cmp++; if (cpu_gnt !== exp_gnt) begin n_err++; $display("FAIL rnd_gnt k%0d: got %b want %b", k, cpu_gnt, exp_gnt); end
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            n_cmp++; if ({cpu_rd_vld, cpu_rd_data} !== {1'b1, dat_q[0]}) begin
               n_err++; $display("FAIL rnd_rd k%0d: got %b %h want 1 %h", k, cpu_rd_vld, cpu_rd_data, dat_q[0]);
            end
            void'(due_q.pop_front()); void'(dat_q.pop_front());
         end else begin
            n_cmp++; if (cpu_rd_vld !== 1'b0) begin n_err++; $display("FAIL rnd_spurious_vld k%0d: got %b want 0", k, cpu_rd_vld); end
         end
         if (ex_wrt_en) ref_mem[ex_addr[15:2]] = ex_wrt_data;
         if (exp_gnt) begin
            if (cpu_wrt) ref_mem[cpu_addr[15:2]] = cpu_wrt_data;
            else begin due_q.push_back(cyc + 2); dat_q.push_back(ref_mem[cpu_addr[15:2]]); end
         end
         granted_last = exp_gnt;
      end
      n_cmp++; if (due_q.size() != 0) begin n_err++; $display("FAIL rnd_lost_reads: got %0d outstanding want 0", due_q.size()); end
      idle_inputs();
   endtask

   task automatic test_starvation();
      int           t0, done_at, beats;
      logic [15:0]  a;
      logic [511:0] exp_blk;
      step(); accel_req = 1; accel_wrt = 0; accel_base = 16'h0200;
      cpu_req = 1; cpu_wrt = 0; cpu_addr = 16'h4000;
      sample(); t0 = cyc;
      step(); accel_req = 0;
      beats = 0;
`ifdef ARB_STARVE_GUARD_EN
      for (int k = 0; k < 45; k++) begin
         sample();
         n_cmp++; if (cpu_gnt !== ((k % 9) != 8)) begin
            n_err++; $display("FAIL starve_pattern k%0d: got %b want %b", k, cpu_gnt, (k % 9) != 8);
         end
         if (!cpu_gnt) beats++;
         step();
      end
      n_cmp++; if (beats != 5) begin n_err++; $display("FAIL starve_beats: got %0d want 5", beats); end
`else
      for (int k = 0; k < 30; k++) begin
         sample();
         n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL starve_cpu_k%0d: got %b want 1", k, cpu_gnt); end
         if (mem_rd_en && mem_addr != 16'h4000) beats++;
         step();
      end
      n_cmp++; if (beats != 0) begin n_err++; $display("FAIL starve_beats: got %0d want 0", beats); end
`endif
      cpu_req = 0;
      done_at = -1;
      for (int k = 0; k < 40 && done_at < 0; k++) begin
         sample();
         if (accel_done) done_at = cyc - t0;
         else step();
      end
      n_cmp++; if (done_at < 0) begin n_err++; $display("FAIL starve_done: got none want pulse within 40 cycles"); end
      for (int i = 0; i < 16; i++) begin
         a = 16'h0200 + 16'(4 * i);
         exp_blk[32*i +: 32] = ref_mem[a[15:2]];
      end
      n_cmp++; if (accel_rd_data !== exp_blk) begin n_err++; $display("FAIL starve_block: got %h want %h", accel_rd_data, exp_blk); end
   endtask

   task automatic test_reset_mid_burst();
      logic [598:0] outs;
      int           pulses;
      step(); accel_req = 1; accel_wrt = 1; accel_base = 16'h0300; accel_wrt_data = $urandom;
      sample();
      pulses = 0;
      for (int k = 0; k < 30 && pulses < 5; k++) begin
         step(); accel_req = 0; accel_wrt_data = $urandom;
         sample();
         if (accel_beat_rdy) pulses++;
      end
      n_cmp++; if (pulses != 5) begin n_err++; $display("FAIL mid_pulses: got %0d want 5", pulses); end
      step(); idle_inputs();
      #1 rst_n = 0;
      #1;
      outs = {cpu_gnt, cpu_rd_vld, cpu_rd_data, accel_beat_rdy, accel_busy, accel_done,
              accel_rd_data, mem_addr, mem_wrt_data, mem_wrt_en, mem_rd_en};
      n_cmp++; if (outs !== '0) begin n_err++; $display("FAIL mid_reset_outputs: got %h want 0", outs); end
      for (int k = 0; k < 6; k++) begin
         if (k == 3) begin step(); rst_n = 1; end
         sample();
         n_cmp++; if ({accel_busy, accel_done} !== 2'b00) begin
            n_err++; $display("FAIL mid_idle_k%0d: got busy %b done %b want 0 0", k, accel_busy, accel_done);
         end
      end
      test_write_burst(16'h0400);
   endtask

   initial begin
      mseed = $urandom;
      for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
      idle_inputs();
      test_reset();
      test_ex_priority();
      test_read_burst(16'h0100);
      test_write_burst(16'hFFF0);
      test_cpu_read_ex();
      test_random_traffic();
      test_starvation();
      test_reset_mid_burst();
      test_read_burst(16'hFFF0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
